// File: rtl/override_reg_bank.sv
// rtl/override_reg_bank.sv - per-channel register bank with assign/deassign style override
//
// Purpose:
//   CHANNELS independent WIDTH-bit registers. Each one is normally loaded by wr_en/wr_data.
//   A channel can also be pinned to a live override source, either until ovr_clr or for a
//   programmed number of cycles. Writes that arrive while a channel is pinned are discarded
//   and flagged in a sticky per-channel bit.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   wr_en, wr_data   per-channel normal write (lane c at [c*WIDTH +: WIDTH])
//   ovr_set, ovr_clr per-channel override request / release
//   ovr_src          live override value, same lane packing
//   ovr_hold_cycles  hold length captured on ovr_set, 0 = hold until ovr_clr
//   blocked_clr      zeroes every wr_blocked bit
//   q                register contents
//   ovr_active       channel is currently overridden
//   wr_blocked       sticky: a write to this channel was discarded
module override_reg_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    parameter int TIMER_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       wr_en,
    input  logic [CHANNELS*WIDTH-1:0] wr_data,
    input  logic [CHANNELS-1:0]       ovr_set,
    input  logic [CHANNELS-1:0]       ovr_clr,
    input  logic [CHANNELS*WIDTH-1:0] ovr_src,
    input  logic [TIMER_W-1:0]        ovr_hold_cycles,
    input  logic                      blocked_clr,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       ovr_active,
    output logic [CHANNELS-1:0]       wr_blocked
);

    typedef enum logic {
        ST_NORMAL   = 1'b0,
        ST_OVERRIDE = 1'b1
    } state_t;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        state_t             state_q, state_d;
        logic [WIDTH-1:0]   reg_q, reg_d;
        logic [TIMER_W-1:0] timer_q, timer_d;
        logic               blk_q;
        logic               blk_ev;
        logic               release_ev;

        always_comb begin
            state_d = state_q;
            reg_d   = reg_q;
            timer_d = timer_q;
            blk_ev  = 1'b0;
            // A re-arm on the last held cycle reloads the timer instead of letting it expire;
            // an explicit ovr_clr always wins.
            release_ev = ovr_clr[c] || ((timer_q == TIMER_W'(1)) && !ovr_set[c]);

            case (state_q)
                ST_NORMAL: begin
                    if (ovr_set[c] && !ovr_clr[c]) begin
                        state_d = ST_OVERRIDE;
                        reg_d   = ovr_src[c*WIDTH +: WIDTH];
                        timer_d = ovr_hold_cycles;
                        blk_ev  = wr_en[c];
                    end else if (wr_en[c]) begin
                        reg_d = wr_data[c*WIDTH +: WIDTH];
                    end
                end
                ST_OVERRIDE: begin
                    if (release_ev) begin
                        // Register keeps the last forced value unless a write lands on this edge.
                        state_d = ST_NORMAL;
                        timer_d = '0;
                        if (wr_en[c]) begin
                            reg_d = wr_data[c*WIDTH +: WIDTH];
                        end
                    end else begin
                        reg_d  = ovr_src[c*WIDTH +: WIDTH];
                        blk_ev = wr_en[c];
                        if (ovr_set[c]) begin
                            timer_d = ovr_hold_cycles;
                        end else if (timer_q != '0) begin
                            timer_d = timer_q - TIMER_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_NORMAL;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_NORMAL;
                reg_q   <= '0;
                timer_q <= '0;
                blk_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                reg_q   <= reg_d;
                timer_q <= timer_d;
                if (blk_ev) begin
                    blk_q <= 1'b1;
                end else if (blocked_clr) begin
                    blk_q <= 1'b0;
                end
            end
        end

        assign q[c*WIDTH +: WIDTH] = reg_q;
        assign ovr_active[c]       = (state_q == ST_OVERRIDE);
        assign wr_blocked[c]       = blk_q;
    end

endmodule

// File: tb/tb_override_reg_bank.sv
// tb/tb_override_reg_bank.sv - self-checking bench for override_reg_bank
module tb_override_reg_bank;

    localparam int CH = 4;
    localparam int W  = 32;
    localparam int TW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   wr_en;
    logic [CH*W-1:0] wr_data;
    logic [CH-1:0]   ovr_set;
    logic [CH-1:0]   ovr_clr;
    logic [CH*W-1:0] ovr_src;
    logic [TW-1:0]   ovr_hold_cycles;
    logic            blocked_clr;
    logic [CH*W-1:0] q;
    logic [CH-1:0]   ovr_active;
    logic [CH-1:0]   wr_blocked;

    override_reg_bank #(.CHANNELS(CH), .WIDTH(W), .TIMER_W(TW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .ovr_set(ovr_set), .ovr_clr(ovr_clr), .ovr_src(ovr_src),
        .ovr_hold_cycles(ovr_hold_cycles), .blocked_clr(blocked_clr),
        .q(q), .ovr_active(ovr_active), .wr_blocked(wr_blocked)
    );

    always #5 clk = ~clk;

    // Reference model: each override carries the absolute edge index on which it expires.
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [W-1:0] m_q   [CH];
    bit           m_act [CH];
    bit           m_blk [CH];
    int           m_dead[CH];

    task automatic model_edge();
        bit blk_ev;
        bit rel;
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                m_q[c] = '0; m_act[c] = 0; m_blk[c] = 0; m_dead[c] = -1;
            end else begin
                blk_ev = 0;
                if (!m_act[c]) begin
                    if (ovr_set[c] && !ovr_clr[c]) begin
                        m_act[c]  = 1;
                        m_q[c]    = ovr_src[c*W +: W];
                        m_dead[c] = (ovr_hold_cycles == 0) ? -1 : cyc + int'(ovr_hold_cycles);
                        blk_ev    = wr_en[c];
                    end else if (wr_en[c]) begin
                        m_q[c] = wr_data[c*W +: W];
                    end
                end else begin
                    rel = ovr_clr[c] || (m_dead[c] == cyc && !ovr_set[c]);
                    if (rel) begin
                        m_act[c]  = 0;
                        m_dead[c] = -1;
                        if (wr_en[c]) m_q[c] = wr_data[c*W +: W];
                    end else begin
                        m_q[c] = ovr_src[c*W +: W];
                        blk_ev = wr_en[c];
                        if (ovr_set[c])
                            m_dead[c] = (ovr_hold_cycles == 0) ? -1 : cyc + int'(ovr_hold_cycles);
                    end
                end
                if (blk_ev) m_blk[c] = 1;
                else if (blocked_clr) m_blk[c] = 0;
            end
        end
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [CH*W-1:0] obs, input logic [CH*W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [CH*W-1:0] eq;
        logic [CH-1:0]   ea, eb;
        for (int c = 0; c < CH; c++) begin
            eq[c*W +: W] = m_q[c];
            ea[c]        = m_act[c];
            eb[c]        = m_blk[c];
        end
        chk("model_q", q, eq);
        chk("model_ovr_active", {{(CH*W-CH){1'b0}}, ovr_active}, {{(CH*W-CH){1'b0}}, ea});
        chk("model_wr_blocked", {{(CH*W-CH){1'b0}}, wr_blocked}, {{(CH*W-CH){1'b0}}, eb});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
        rst = 0; wr_en = '0; ovr_set = '0; ovr_clr = '0; blocked_clr = 0;
    endtask

    function automatic logic [W-1:0] lane(input logic [CH*W-1:0] v, input int c);
        return v[c*W +: W];
    endfunction

    int cnt;

    initial begin
        rst = 1; wr_en = '0; wr_data = '0; ovr_set = '0; ovr_clr = '0;
        ovr_src = '0; ovr_hold_cycles = '0; blocked_clr = 0;
        for (int c = 0; c < CH; c++) begin m_q[c] = 'x; m_act[c] = 0; m_blk[c] = 0; m_dead[c] = -1; end
        #1;
        step(); rst = 1; step();
        chk("reset_q", q, '0);
        chk("reset_flags", {{(CH*W-8){1'b0}}, ovr_active, wr_blocked}, '0);

        // plain write
        wr_en[0] = 1; wr_data[0*W +: W] = 32'h5;
        step();
        chk("t1_q0", W'(lane(q, 0)), 32'h5);
        chk("t1_others", q[CH*W-1:W], '0);

        // indefinite override tracking a counting source
        ovr_hold_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            ovr_src[1*W +: W] = i;
            if (i == 0) ovr_set[1] = 1;
            step();
        end
        chk("t2_q1_tracks", W'(lane(q, 1)), 32'd99);
        ovr_src[1*W +: W] = 100; ovr_clr[1] = 1;
        step();
        chk("t2_q1_frozen", W'(lane(q, 1)), 32'd99);
        chk("t2_inactive", W'(ovr_active[1]), 0);

        // timed override of 3 edges
        ovr_hold_cycles = 3; ovr_src[2*W +: W] = 32'hA; ovr_set[2] = 1;
        step();
        cnt = int'(ovr_active[2]);
        repeat (4) begin step(); cnt += int'(ovr_active[2]); end
        chk("t3_active_edges", cnt, 3);
        chk("t3_q2_held", W'(lane(q, 2)), 32'hA);
        wr_en[2] = 1; wr_data[2*W +: W] = 32'h1;
        step();
        chk("t3_q2_write", W'(lane(q, 2)), 32'h1);

        // blocked writes
        ovr_hold_cycles = 0; ovr_src[3*W +: W] = 32'h33; ovr_set[3] = 1;
        step();
        wr_en[3] = 1; wr_data[3*W +: W] = 32'h55;
        step();
        chk("t4_q3_kept", W'(lane(q, 3)), 32'h33);
        chk("t4_blocked", W'(wr_blocked[3]), 1);
        step();
        chk("t4_sticky", W'(wr_blocked[3]), 1);
        blocked_clr = 1;
        step();
        chk("t4_cleared", W'(wr_blocked[3]), 0);
        blocked_clr = 1; wr_en[3] = 1;
        step();
        chk("t4_set_wins", W'(wr_blocked[3]), 1);
        ovr_clr[3] = 1; blocked_clr = 1;
        step();

        // simultaneity on channel 0
        ovr_hold_cycles = 0; ovr_src[0*W +: W] = 32'h77; ovr_set[0] = 1;
        step();
        ovr_clr[0] = 1; wr_en[0] = 1; wr_data[0*W +: W] = 32'h88;
        step();
        chk("t5a_q0", W'(lane(q, 0)), 32'h88);
        chk("t5a_flags", W'({ovr_active[0], wr_blocked[0]}), 0);
        ovr_src[0*W +: W] = 32'h66; ovr_set[0] = 1; wr_en[0] = 1; wr_data[0*W +: W] = 32'h99;
        step();
        chk("t5b_q0", W'(lane(q, 0)), 32'h66);
        chk("t5b_flags", W'({ovr_active[0], wr_blocked[0]}), 2'b11);
        ovr_clr[0] = 1; blocked_clr = 1;
        step();
        ovr_set[0] = 1; ovr_clr[0] = 1;
        step();
        chk("t5c_normal", W'(ovr_active[0]), 0);
        ovr_hold_cycles = 2; ovr_set[0] = 1;
        step();
        step();
        ovr_set[0] = 1;
        step();
        cnt = int'(ovr_active[0]);
        repeat (3) begin step(); cnt += int'(ovr_active[0]); end
        chk("t5d_rearm_edges", cnt, 2);

        // reset in the middle of timed overrides
        ovr_hold_cycles = 50; ovr_set[1] = 1; ovr_set[2] = 1;
        step();
        step();
        rst = 1;
        step();
        chk("t6_q_zero", q, '0);
        chk("t6_flags_zero", {{(CH*W-8){1'b0}}, ovr_active, wr_blocked}, '0);
        repeat (5) step();
        chk("t6_stays_normal", W'(ovr_active), 0);

        // randomized traffic against the model
        repeat (500) begin
            for (int c = 0; c < CH; c++) begin
                wr_en[c]   = ($urandom_range(0, 3) == 0);
                ovr_set[c] = ($urandom_range(0, 5) == 0);
                ovr_clr[c] = ($urandom_range(0, 9) == 0);
                wr_data[c*W +: W] = $urandom;
                ovr_src[c*W +: W] = $urandom;
            end
            ovr_hold_cycles = TW'($urandom_range(0, 5));
            blocked_clr = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
